// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - general register file with pending-write scoreboard and WB->ID bypass
// Two combinational read ports, one clocked write port, per-register outstanding-write counters.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int BYPASS = 1,
    parameter int TRACE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_wa,
    output logic              iss_full,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       wpc,
    output logic              err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0][CNT_W-1:0]  cnt;

    logic wr_nz;
    logic dec;
    logic underflow;
    logic dec_on_iss;
    logic full_raw;
    logic inc;
    logic byp1;
    logic byp2;

    always_comb begin
        wr_nz      = we && (wa != '0);
        dec        = wr_nz && (cnt[wa] != '0);
        underflow  = wr_nz && (cnt[wa] == '0);
        dec_on_iss = dec && (wa == iss_wa);
        // a writeback to the same register this cycle frees a slot, so no refusal
        full_raw   = iss_en && (iss_wa != '0) && (cnt[iss_wa] == CNT_MAX) && !dec_on_iss;
        inc        = iss_en && (iss_wa != '0) && !full_raw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (wr_nz) begin
                regs[wa] <= wd;
            end
            if (underflow) begin
                err <= 1'b1;
            end
            if (inc && !(dec && (wa == iss_wa))) begin
                cnt[iss_wa] <= cnt[iss_wa] + CNT_W'(1);
            end
            if (dec && !(inc && (iss_wa == wa))) begin
                cnt[wa] <= cnt[wa] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd1      = '0;
        rd2      = '0;
        byp1     = (BYPASS != 0) && we && (wa == ra1) && (cnt[ra1] != '0);
        byp2     = (BYPASS != 0) && we && (wa == ra2) && (cnt[ra2] != '0);
        rd1_busy = 1'b0;
        rd2_busy = 1'b0;
        iss_full = 1'b0;
        if (!reset) begin
            if (ra1 != '0) begin
                rd1 = ((BYPASS != 0) && we && (wa == ra1)) ? wd : regs[ra1];
            end
            if (ra2 != '0) begin
                rd2 = ((BYPASS != 0) && we && (wa == ra2)) ? wd : regs[ra2];
            end
            // the forwarded write satisfies one of the outstanding writes
            rd1_busy = (ra1 != '0) && ((cnt[ra1] - CNT_W'(byp1)) != '0);
            rd2_busy = (ra2 != '0) && ((cnt[ra2] - CNT_W'(byp2)) != '0);
            iss_full = full_raw;
        end
    end

    if (TRACE != 0) begin : g_trace
        always @(posedge clk) begin
            if (!reset && we) begin
                $display("@%h: $%d <= %h", wpc, wa, wd);
            end
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - directed table-driven bench for grf_scoreboard
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, iss_wa, wa;
    logic        iss_en, we;
    logic [31:0] wd, wpc;

    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        rd1_busy, rd2_busy, iss_full, err;
    logic        nb_rd1_busy, nb_rd2_busy, nb_iss_full, nb_err;

    always #5 clk = ~clk;

    grf_scoreboard u_dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .iss_en(iss_en), .iss_wa(iss_wa),
        .iss_full(iss_full), .we(we), .wa(wa), .wd(wd), .wpc(wpc), .err(err)
    );

    grf_scoreboard #(.BYPASS(0), .TRACE(0)) u_nb (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
        .rd1_busy(nb_rd1_busy), .rd2_busy(nb_rd2_busy), .iss_en(iss_en), .iss_wa(iss_wa),
        .iss_full(nb_iss_full), .we(we), .wa(wa), .wd(wd), .wpc(wpc), .err(nb_err)
    );

    typedef struct {
        logic        iss_en;
        logic [4:0]  iss_wa;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        full;
        logic        err;
        logic [31:0] nb_rd2;
        logic        nb_b2;
    } vec_t;

    localparam int NV = 27;
    vec_t v [NV];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(input logic ie, input logic [4:0] iw, input logic w,
                                input logic [4:0] a, input logic [31:0] d,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic eb1, input logic eb2, input logic ef,
                                input logic ee, input logic [31:0] n2, input logic nb2);
        vec_t t;
        t.iss_en = ie; t.iss_wa = iw; t.we = w; t.wa = a; t.wd = d;
        t.ra1 = r1; t.ra2 = r2; t.rd1 = e1; t.rd2 = e2; t.b1 = eb1; t.b2 = eb2;
        t.full = ef; t.err = ee; t.nb_rd2 = n2; t.nb_b2 = nb2;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        iss_en = 1'b0; iss_wa = '0; we = 1'b0; wa = '0; wd = '0; wpc = '0;
    endtask

    initial begin
        //         ie iss we wa  wd             ra1 ra2 | rd1           rd2           b1 b2 fu er nb_rd2        nb_b2
        v[0]  = mk(0, 0, 0, 0, 32'h0,          0, 0,    32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[1]  = mk(1, 5, 0, 0, 32'h0,          5, 0,    32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[2]  = mk(0, 0, 1, 5, 32'h1234,       5, 0,    32'h1234,     32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[3]  = mk(0, 0, 0, 0, 32'h0,          5, 0,    32'h1234,     32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[4]  = mk(0, 0, 1, 0, 32'hFFFFFFFF,   0, 5,    32'h0,        32'h1234,     0, 0, 0, 0, 32'h1234,     0);
        v[5]  = mk(0, 0, 0, 0, 32'h0,          0, 5,    32'h0,        32'h1234,     0, 0, 0, 0, 32'h1234,     0);
        v[6]  = mk(1, 7, 0, 0, 32'h0,          0, 7,    32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[7]  = mk(0, 0, 0, 0, 32'h0,          0, 7,    32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        1);
        v[8]  = mk(0, 0, 1, 7, 32'hAB,         0, 7,    32'h0,        32'hAB,       0, 0, 0, 0, 32'h0,        1);
        v[9]  = mk(0, 0, 0, 0, 32'h0,          0, 7,    32'h0,        32'hAB,       0, 0, 0, 0, 32'hAB,       0);
        v[10] = mk(1, 3, 0, 0, 32'h0,          0, 0,    32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[11] = mk(1, 3, 0, 0, 32'h0,          0, 0,    32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[12] = mk(1, 3, 0, 0, 32'h0,          0, 0,    32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[13] = mk(1, 3, 0, 0, 32'h0,          3, 0,    32'h0,        32'h0,        1, 0, 1, 0, 32'h0,        0);
        v[14] = mk(1, 3, 1, 3, 32'h33,         3, 0,    32'h33,       32'h0,        1, 0, 0, 0, 32'h0,        0);
        v[15] = mk(0, 0, 1, 3, 32'h44,         3, 3,    32'h44,       32'h44,       1, 1, 0, 0, 32'h33,       1);
        v[16] = mk(0, 0, 1, 3, 32'h55,         0, 3,    32'h0,        32'h55,       0, 1, 0, 0, 32'h44,       1);
        v[17] = mk(0, 0, 1, 3, 32'h66,         0, 3,    32'h0,        32'h66,       0, 0, 0, 0, 32'h55,       1);
        v[18] = mk(0, 0, 0, 0, 32'h0,          0, 3,    32'h0,        32'h66,       0, 0, 0, 0, 32'h66,       0);
        v[19] = mk(0, 0, 1, 9, 32'h99,         9, 0,    32'h99,       32'h0,        0, 0, 0, 0, 32'h0,        0);
        v[20] = mk(0, 0, 0, 0, 32'h0,          9, 0,    32'h99,       32'h0,        0, 0, 0, 1, 32'h0,        0);
        v[21] = mk(1, 9, 0, 0, 32'h0,          9, 0,    32'h99,       32'h0,        0, 0, 0, 1, 32'h0,        0);
        v[22] = mk(0, 0, 1, 9, 32'hA0,         9, 0,    32'hA0,       32'h0,        0, 0, 0, 1, 32'h0,        0);
        v[23] = mk(0, 0, 0, 0, 32'h0,          9, 0,    32'hA0,       32'h0,        0, 0, 0, 1, 32'h0,        0);
        v[24] = mk(1, 4, 0, 0, 32'h0,          4, 0,    32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        0);
        v[25] = mk(1, 6, 1, 4, 32'h4,          4, 6,    32'h4,        32'h0,        0, 0, 0, 1, 32'h0,        0);
        v[26] = mk(0, 0, 0, 0, 32'h0,          4, 6,    32'h4,        32'h0,        0, 1, 0, 1, 32'h0,        1);

        reset = 1'b1; ra1 = 5'd5; ra2 = 5'd5; idle();
        #2;
        chk("reset_rd1", -1, rd1, 32'h0);
        chk("reset_err", -1, {31'b0, err}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            iss_en = v[i].iss_en; iss_wa = v[i].iss_wa; we = v[i].we; wa = v[i].wa;
            wd = v[i].wd; ra1 = v[i].ra1; ra2 = v[i].ra2;
            wpc = (i == 2) ? 32'h3000 : 32'h1000 + 32'(i) * 4;
            #2;
            chk("rd1", i, rd1, v[i].rd1);
            chk("rd2", i, rd2, v[i].rd2);
            chk("rd1_busy", i, {31'b0, rd1_busy}, {31'b0, v[i].b1});
            chk("rd2_busy", i, {31'b0, rd2_busy}, {31'b0, v[i].b2});
            chk("iss_full", i, {31'b0, iss_full}, {31'b0, v[i].full});
            chk("err", i, {31'b0, err}, {31'b0, v[i].err});
            chk("nb_rd2", i, nb_rd2, v[i].nb_rd2);
            chk("nb_rd2_busy", i, {31'b0, nb_rd2_busy}, {31'b0, v[i].nb_b2});
            chk("nb_iss_full", i, {31'b0, nb_iss_full}, {31'b0, v[i].full});
            chk("nb_err", i, {31'b0, nb_err}, {31'b0, v[i].err});
        end

        // asynchronous reset between edges with live state, and we/iss_en ignored while held
        @(negedge clk);
        idle(); ra1 = 5'd9; ra2 = 5'd6;
        #2;
        chk("pre_rst_rd1", 100, rd1, 32'hA0);
        chk("pre_rst_busy2", 100, {31'b0, rd2_busy}, 32'h1);
        #1;
        reset = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h123; iss_en = 1'b1; iss_wa = 5'd6;
        #1;
        chk("arst_rd1", 101, rd1, 32'h0);
        chk("arst_rd2", 101, rd2, 32'h0);
        chk("arst_busy2", 101, {31'b0, rd2_busy}, 32'h0);
        chk("arst_err", 101, {31'b0, err}, 32'h0);
        chk("arst_full", 101, {31'b0, iss_full}, 32'h0);
        chk("arst_nb_rd1", 101, nb_rd1, 32'h0);
        chk("arst_nb_busy1", 101, {31'b0, nb_rd1_busy}, 32'h0);
        @(posedge clk);
        #1;
        chk("hold_rd1", 102, rd1, 32'h0);
        @(negedge clk);
        reset = 1'b0; idle();
        #2;
        chk("post_rst_rd1", 103, rd1, 32'h0);
        chk("post_rst_busy2", 103, {31'b0, rd2_busy}, 32'h0);
        chk("post_rst_err", 103, {31'b0, err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
